// File: rtl/lif_pkg.sv
// Shared types and constants for the lif_array neuron block: coupling
// mode and FSM state enums, default parameter values, and the LFSR
// seed/taps used by the optional noise source.
package lif_pkg;

    typedef enum logic [1:0] {
        LIF_INDEP = 2'd0,
        LIF_EXC   = 2'd1,
        LIF_INH   = 2'd2,
        LIF_RING  = 2'd3
    } lif_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } lif_state_e;

    localparam int unsigned LIF_N_DEF         = 4;
    localparam int unsigned LIF_W_DEF         = 8;
    localparam int unsigned LIF_CW_DEF        = 5;
    localparam int unsigned LIF_THRESHOLD_DEF = 200;
    localparam int unsigned LIF_RESET_POT_DEF = 50;
    localparam int unsigned LIF_LEAK_DEF      = 5;
    localparam int unsigned LIF_REFRAC_DEF    = 10;

    // Fibonacci LFSR, taps 16,14,13,11 -> register bits 15,13,12,10
    localparam logic [15:0] LIF_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LIF_LFSR_TAPS = 16'hB400;

    function automatic logic lif_lfsr_fb(input logic [15:0] s);
        return ^(s & LIF_LFSR_TAPS);
    endfunction

endpackage

// File: rtl/lif_array_if.sv
// Stimulus/config and readout bundle for lif_array. The master side
// drives enable, tick, currents, coupling config and readout address.
interface lif_array_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 5
);
    logic                 ena;
    logic                 tick;
    logic [N*CW-1:0]      base_current;
    logic [1:0]           mode;
    logic [3:0]           gain;
    logic                 busy;
    logic                 done;
    logic [N-1:0]         spikes;
    logic                 overrun;
    logic [$clog2(N)-1:0] rd_addr;
    logic [W-1:0]         rd_potential;

    modport master (
        output ena, tick, base_current, mode, gain, rd_addr,
        input  busy, done, spikes, overrun, rd_potential
    );

    modport slave (
        input  ena, tick, base_current, mode, gain, rd_addr,
        output busy, done, spikes, overrun, rd_potential
    );
endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron update: refractory countdown, or
// integrate (potential + current + coupling - leak + noise) with
// saturation to 0..2^W-1 and threshold/spike decision.
module lif_update
    import lif_pkg::*;
#(
    parameter int          W         = 8,
    parameter int          CW        = 5,
    parameter int          RW        = 4,
    parameter int          SW        = 21,
    parameter int unsigned THRESHOLD = 200,
    parameter int unsigned RESET_POT = 50,
    parameter int unsigned LEAK      = 5,
    parameter int unsigned REFRAC    = 10
) (
    input  logic [W-1:0]         i_v,
    input  logic [RW-1:0]        i_refr,
    input  logic [CW-1:0]        i_cur,
    input  logic signed [SW-1:0] i_coup,
    input  logic [1:0]           i_noise,
    output logic [W-1:0]         o_v_next,
    output logic [RW-1:0]        o_refr_next,
    output logic                 o_spike
);
    localparam logic signed [SW-1:0] VMAX = SW'((2**W) - 1);

    logic signed [SW-1:0] w_sum;
    logic [W-1:0]         w_sat;

    // Wide signed sum, clamped so the potential never wraps
    always_comb begin
        w_sum = $signed(SW'(i_v)) + $signed(SW'(i_cur)) + i_coup
              - $signed(SW'(LEAK)) + $signed(SW'(i_noise));
        if (w_sum[SW-1]) begin
            w_sat = '0;
        end else if (w_sum > VMAX) begin
            w_sat = '1;
        end else begin
            w_sat = w_sum[W-1:0];
        end
    end

    // Refractory hold, or spike/integrate decision
    always_comb begin
        o_v_next    = W'(RESET_POT);
        o_refr_next = '0;
        o_spike     = 1'b0;
        if (i_refr != '0) begin
            o_refr_next = i_refr - RW'(1);
        end else if (32'(w_sat) >= THRESHOLD) begin
            o_spike     = 1'b1;
            o_refr_next = RW'(REFRAC);
        end else begin
            o_v_next = w_sat;
        end
    end
endmodule

// File: rtl/lif_array.sv
// Time-multiplexed array of N leaky integrate-and-fire neurons sharing
// one lif_update datapath. Each accepted tick walks neurons 0..N-1, one
// per enabled cycle, coupling through the previous timestep's spikes.
// Optional feature: define LIF_ARRAY_NOISE_EN to add 0..3 LFSR noise to
// every non-refractory update.
module lif_array
    import lif_pkg::*;
#(
    parameter int          N         = LIF_N_DEF,
    parameter int          W         = LIF_W_DEF,
    parameter int          CW        = LIF_CW_DEF,
    parameter int unsigned THRESHOLD = LIF_THRESHOLD_DEF,
    parameter int unsigned RESET_POT = LIF_RESET_POT_DEF,
    parameter int unsigned LEAK      = LIF_LEAK_DEF,
    parameter int unsigned REFRAC    = LIF_REFRAC_DEF
) (
    input logic         clk,
    input logic         rst,
    lif_array_if.slave  bus
);
    localparam int RW = $clog2(REFRAC + 1);
    localparam int AW = $clog2(N);
    localparam int SW = W + CW + 8;

    lif_state_e           r_state, w_state_nxt;
    logic [AW-1:0]        r_idx;
    logic [W-1:0]         r_v    [N];
    logic [RW-1:0]        r_refr [N];
    logic [N-1:0]         r_prev_spk, r_new_spk, r_spikes;
    logic                 r_done, r_overrun;
    logic [W-1:0]         r_rd;

    logic                 w_start, w_update, w_last;
    logic [CW-1:0]        w_cur;
    logic [4:0]           w_k;
    logic [8:0]           w_c;
    logic [AW-1:0]        w_ring_src;
    logic signed [SW-1:0] w_coup;
    logic [1:0]           w_noise;
    logic [W-1:0]         w_v_nxt;
    logic [RW-1:0]        w_refr_nxt;
    logic                 w_spike;

    assign w_start  = (r_state == ST_IDLE) && bus.ena && bus.tick;
    assign w_update = (r_state == ST_RUN) && bus.ena;
    assign w_last   = (r_idx == AW'(N - 1));
    assign w_cur    = bus.base_current[32'(r_idx) * CW +: CW];

    // Coupling term for the neuron currently being updated
    always_comb begin
        w_k = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if ((i != 32'(r_idx)) && r_prev_spk[i]) begin
                w_k = w_k + 5'd1;
            end
        end
        w_c        = 9'(bus.gain) * 9'(w_k);
        w_ring_src = (r_idx == '0) ? AW'(N - 1) : r_idx - AW'(1);
        w_coup     = '0;
        case (lif_mode_e'(bus.mode))
            LIF_INDEP: w_coup = '0;
            LIF_EXC:   w_coup = $signed(SW'(w_c));
            LIF_INH:   w_coup = -$signed(SW'({w_c, 1'b0}));
            LIF_RING:  w_coup = r_prev_spk[w_ring_src] ? $signed(SW'(bus.gain)) : '0;
            default:   w_coup = '0;
        endcase
    end

`ifdef LIF_ARRAY_NOISE_EN
    logic [15:0] r_lfsr;

    // Noise source advances once per neuron update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LIF_LFSR_SEED;
        end else if (w_update) begin
            r_lfsr <= {r_lfsr[14:0], lif_lfsr_fb(r_lfsr)};
        end
    end

    assign w_noise = r_lfsr[1:0];
`else
    assign w_noise = 2'b00;
`endif

    lif_update #(
        .W         (W),
        .CW        (CW),
        .RW        (RW),
        .SW        (SW),
        .THRESHOLD (THRESHOLD),
        .RESET_POT (RESET_POT),
        .LEAK      (LEAK),
        .REFRAC    (REFRAC)
    ) u_update (
        .i_v         (r_v[r_idx]),
        .i_refr      (r_refr[r_idx]),
        .i_cur       (w_cur),
        .i_coup      (w_coup),
        .i_noise     (w_noise),
        .o_v_next    (w_v_nxt),
        .o_refr_next (w_refr_nxt),
        .o_spike     (w_spike)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: start on tick, return after the last neuron
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_update && w_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Neuron state arrays, index counter, spike vectors and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_v[i]    <= W'(RESET_POT);
                r_refr[i] <= '0;
            end
            r_idx      <= '0;
            r_prev_spk <= '0;
            r_new_spk  <= '0;
            r_spikes   <= '0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.ena) begin
                if (w_start) begin
                    r_prev_spk <= r_spikes;
                    r_idx      <= '0;
                    r_new_spk  <= '0;
                end
                if ((r_state == ST_RUN) && bus.tick) begin
                    r_overrun <= 1'b1;
                end
                if (w_update) begin
                    r_v[r_idx]       <= w_v_nxt;
                    r_refr[r_idx]    <= w_refr_nxt;
                    r_new_spk[r_idx] <= w_spike;
                    r_idx            <= r_idx + AW'(1);
                    if (w_last) begin
                        // last neuron's spike is merged here since new_spk lags a cycle
                        r_spikes <= r_new_spk | (N'(w_spike) << r_idx);
                        r_done   <= 1'b1;
                    end
                end
            end
        end
    end

    // Registered potential readout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd <= W'(RESET_POT);
        end else if (32'(bus.rd_addr) < N) begin
            r_rd <= r_v[bus.rd_addr];
        end
    end

    assign bus.busy         = (r_state == ST_RUN);
    assign bus.done         = r_done;
    assign bus.spikes       = r_spikes;
    assign bus.overrun      = r_overrun;
    assign bus.rd_potential = r_rd;
endmodule
